// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, redirect flush, EX forwarding,
// whole-pipeline freeze for multi-cycle data-memory accesses, stall-cycle counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_op,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TCNT_W = (MEM_TIMEOUT > 16) ? $clog2(MEM_TIMEOUT) : 4;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1
  } state_t;

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic                hz;
  logic                freeze_int;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      sel = 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    hz = ex_is_load && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // A timed-out access is treated as complete: the pipeline advances and mem_err flags it.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    mem_err_d  = 1'b0;
    freeze_int = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_op && !dmem_ack) begin
          freeze_int = 1'b1;
          state_d    = S_MEMWAIT;
          tcnt_d     = TCNT_W'(1);
        end
      end
      S_MEMWAIT: begin
        if (dmem_ack) begin
          state_d = S_RUN;
          tcnt_d  = '0;
        end else if (tcnt_q == TCNT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = S_RUN;
          tcnt_d    = '0;
        end else begin
          freeze_int = 1'b1;
          tcnt_d     = tcnt_q + TCNT_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        tcnt_d  = '0;
      end
    endcase
  end

  // Freeze masks redirect and hazard; both persist because EX holds while frozen.
  always_comb begin
    dmem_req = 1'b0;
    freeze   = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (!rst) begin
      dmem_req = mem_op;
      freeze   = freeze_int;
      fwd_a    = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b    = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      if (!freeze_int) begin
        if (ex_redirect) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (hz) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((freeze_int || (hz && !ex_redirect)) && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      tcnt_q         <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      tcnt_q         <= tcnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences, all checked through an expected-output queue.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_redirect;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic       mem_op;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       dmem_ack;
  } ins_t;

  // Bit order: freeze stall_if stall_id flush_id flush_ex fwd_a fwd_b dmem_req mem_err
  typedef struct packed {
    logic       freeze;
    logic       stall_if;
    logic       stall_id;
    logic       flush_id;
    logic       flush_ex;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       dmem_req;
    logic       mem_err;
  } outs_t;

  typedef struct {
    string name;
    ins_t  in;
    outs_t exp;
  } vec_t;

  localparam outs_t O_NONE  = outs_t'(11'b00000_0000_00);
  localparam outs_t O_STALL = outs_t'(11'b01101_0000_00);
  localparam outs_t O_FLUSH = outs_t'(11'b00011_0000_00);
  localparam outs_t O_FRZ   = outs_t'(11'b10000_0000_10);
  localparam outs_t O_REQ   = outs_t'(11'b00000_0000_10);
  localparam outs_t O_ERR   = outs_t'(11'b00000_0000_01);

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic        mem_regwrite, mem_op, wb_regwrite, dmem_ack;
  logic        dmem_req, stall_if, stall_id, flush_id, flush_ex, freeze, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles;
  logic        s_dmem_req, s_stall_if, s_stall_id, s_flush_id, s_flush_ex, s_freeze, s_mem_err;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [2:0]  s_stall_cycles;

  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  outs_t exp_q[$];
  vec_t  vecs[$];

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_op(mem_op), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .flush_ex(flush_ex), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // Narrow-counter instance so counter saturation is reachable in a short run.
  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_op(mem_op), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_ack(dmem_ack),
    .dmem_req(s_dmem_req), .stall_if(s_stall_if), .stall_id(s_stall_id),
    .flush_id(s_flush_id), .flush_ex(s_flush_ex), .freeze(s_freeze),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err), .stall_cycles(s_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic drive(input ins_t v);
    id_rs1       = v.id_rs1;
    id_rs2       = v.id_rs2;
    id_use_rs1   = v.id_use_rs1;
    id_use_rs2   = v.id_use_rs2;
    ex_rs1       = v.ex_rs1;
    ex_rs2       = v.ex_rs2;
    ex_rd        = v.ex_rd;
    ex_is_load   = v.ex_is_load;
    ex_redirect  = v.ex_redirect;
    mem_rd       = v.mem_rd;
    mem_regwrite = v.mem_regwrite;
    mem_op       = v.mem_op;
    wb_rd        = v.wb_rd;
    wb_regwrite  = v.wb_regwrite;
    dmem_ack     = v.dmem_ack;
  endtask

  task automatic applyStimulus(input ins_t v, input outs_t e);
    drive(v);
    exp_q.push_back(e);
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name);
    outs_t e, a, sa;
    int    sat_exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s got empty-queue expected pending-entry", name);
      return;
    end
    e = exp_q.pop_front();
    a  = {freeze, stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, dmem_req, mem_err};
    sa = {s_freeze, s_stall_if, s_stall_id, s_flush_id, s_flush_ex, s_fwd_a, s_fwd_b,
          s_dmem_req, s_mem_err};
    sat_exp = (exp_cnt > 7) ? 7 : exp_cnt;
    checkVal({name, ":outs"}, 64'(a), 64'(e));
    checkVal({name, ":cnt"}, 64'(stall_cycles), 64'(exp_cnt));
    checkVal({name, ":sat_outs"}, 64'(sa), 64'(e));
    checkVal({name, ":sat_cnt"}, 64'(s_stall_cycles), 64'(sat_exp));
    if (e.freeze || e.stall_if)
      exp_cnt++;
  endtask

  task automatic step(input string name, input ins_t v, input outs_t e);
    @(posedge clk);
    #1;
    applyStimulus(v, e);
    @(negedge clk);
    checkOutput(name);
  endtask

  task automatic addVec(input string n, input ins_t i, input outs_t e);
    vec_t t;
    t.name = n;
    t.in   = i;
    t.exp  = e;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ins_t  v;
    outs_t e;

    // Single-cycle vectors, all starting and ending in S_RUN.
    v = '0;                                                           addVec("idle", v, O_NONE);
    v = '0; v.ex_is_load = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.id_use_rs1 = 1'b1;
    v.id_rs2 = 5'd1;                                                  addVec("lu_rs1", v, O_STALL);
    v.id_use_rs1 = 1'b0;                                              addVec("lu_nouse", v, O_NONE);
    v = '0; v.ex_is_load = 1'b1; v.ex_rd = 5'd5; v.id_rs2 = 5'd5; v.id_use_rs2 = 1'b1;
                                                                      addVec("lu_rs2", v, O_STALL);
    v = '0; v.ex_is_load = 1'b1; v.ex_rd = 5'd0; v.id_rs1 = 5'd0; v.id_use_rs1 = 1'b1;
                                                                      addVec("lu_x0", v, O_NONE);
    v = '0; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.id_use_rs1 = 1'b1;     addVec("nonload", v, O_NONE);
    v = '0; v.ex_rs1 = 5'd7; v.mem_rd = 5'd7; v.mem_regwrite = 1'b1;
    v.wb_rd = 5'd7; v.wb_regwrite = 1'b1;
    e = O_NONE; e.fwd_a = 2'b10;                                      addVec("fwd_mem_pri", v, e);
    v.mem_regwrite = 1'b0;
    e = O_NONE; e.fwd_a = 2'b01;                                      addVec("fwd_wb", v, e);
    v.ex_rs1 = 5'd0; v.mem_rd = 5'd0; v.wb_rd = 5'd0; v.mem_regwrite = 1'b1;
                                                                      addVec("fwd_x0", v, O_NONE);
    v = '0; v.ex_rs1 = 5'd3; v.ex_rs2 = 5'd3; v.mem_rd = 5'd3; v.wb_rd = 5'd3; v.wb_regwrite = 1'b1;
    e = O_NONE; e.fwd_a = 2'b01; e.fwd_b = 2'b01;                     addVec("fwd_ab_wb", v, e);
    v = '0; v.ex_rs1 = 5'd9; v.ex_rs2 = 5'd9; v.mem_rd = 5'd9; v.mem_regwrite = 1'b1;
    v.wb_rd = 5'd9; v.wb_regwrite = 1'b1;
    e = O_NONE; e.fwd_a = 2'b10; e.fwd_b = 2'b10;                     addVec("fwd_ab_mem", v, e);
    v = '0; v.ex_rs2 = 5'd12; v.mem_rd = 5'd12; v.wb_rd = 5'd11; v.wb_regwrite = 1'b1;
                                                                      addVec("fwd_nowe", v, O_NONE);
    v = '0; v.ex_is_load = 1'b1; v.ex_rd = 5'd4; v.id_rs1 = 5'd4; v.id_use_rs1 = 1'b1;
    v.ex_rs2 = 5'd6; v.mem_rd = 5'd6; v.mem_regwrite = 1'b1;
    e = O_STALL; e.fwd_b = 2'b10;                                     addVec("lu_fwd", v, e);
    v = '0; v.ex_is_load = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.id_use_rs1 = 1'b1;
    v.ex_redirect = 1'b1;                                             addVec("redir_hz", v, O_FLUSH);
    v = '0; v.ex_redirect = 1'b1;                                     addVec("redir", v, O_FLUSH);
    v = '0; v.mem_op = 1'b1; v.dmem_ack = 1'b1;                       addVec("mem_zero_wait", v, O_REQ);

    // Reset: combinational outputs forced low even with active-looking inputs.
    rst = 1'b1;
    v = '0; v.mem_op = 1'b1; v.ex_redirect = 1'b1; v.ex_is_load = 1'b1; v.ex_rd = 5'd5;
    v.id_rs1 = 5'd5; v.id_use_rs1 = 1'b1; v.ex_rs1 = 5'd2; v.mem_rd = 5'd2; v.mem_regwrite = 1'b1;
    applyStimulus(v, O_NONE);
    #3;
    checkOutput("reset");
    drive('0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Memory wait: ack three cycles after the request.
    v = '0; v.mem_op = 1'b1;
    for (int i = 0; i < 3; i++)
      step("mw_frz", v, O_FRZ);
    v.dmem_ack = 1'b1;
    step("mw_ack", v, O_REQ);
    step("mw_run", '0, O_NONE);

    // Timeout: no ack ever; abort on the 16th cycle, mem_err one cycle later.
    v = '0; v.mem_op = 1'b1;
    for (int i = 0; i < 15; i++)
      step("to_frz", v, O_FRZ);
    step("to_abort", v, O_REQ);
    step("to_err", '0, O_ERR);
    step("to_err_clr", '0, O_NONE);

    // Redirect and hazard masked by freeze, acted on in the ack cycle.
    v = '0; v.mem_op = 1'b1; v.ex_redirect = 1'b1; v.ex_is_load = 1'b1; v.ex_rd = 5'd5;
    v.id_rs1 = 5'd5; v.id_use_rs1 = 1'b1;
    step("rf_frz1", v, O_FRZ);
    step("rf_frz2", v, O_FRZ);
    v.dmem_ack = 1'b1;
    e = O_FLUSH; e.dmem_req = 1'b1;
    step("rf_ack", v, e);
    step("rf_idle", '0, O_NONE);
    v = '0; v.mem_op = 1'b1; v.ex_is_load = 1'b1; v.ex_rd = 5'd8;
    v.id_rs2 = 5'd8; v.id_use_rs2 = 1'b1;
    step("hf_frz", v, O_FRZ);
    v.dmem_ack = 1'b1;
    e = O_STALL; e.dmem_req = 1'b1;
    step("hf_ack", v, e);
    step("hf_idle", '0, O_NONE);

    // Asynchronous reset in the middle of a memory wait.
    v = '0; v.mem_op = 1'b1;
    step("ar_frz1", v, O_FRZ);
    step("ar_frz2", v, O_FRZ);
    #2;
    rst = 1'b1;
    applyStimulus(v, O_NONE);
    #1;
    exp_cnt = 0;
    checkOutput("async_rst");
    drive('0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("ar_rel1", '0, O_NONE);
    step("ar_rel2", '0, O_NONE);
    v = '0; v.ex_is_load = 1'b1; v.ex_rd = 5'd3; v.id_rs1 = 5'd3; v.id_use_rs1 = 1'b1;
    step("ar_lu", v, O_STALL);
    step("ar_end", '0, O_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It consumes the decoder's use_rs1/use_rs2 and the stage register fields, and produces IF/ID stall, ID/EX flush, EX forwarding selects and a whole-pipeline freeze. The freeze covers multi-cycle data-memory accesses, which use a req/ack handshake with a timeout. It also keeps a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in S_MEMWAIT before abort (≥2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs1  in  5  rs1 field of instruction in ID
id_rs2  in  5  rs2 field of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1 (from decoder)
id_use_rs2  in  1  ID instruction reads rs2 (from decoder)
ex_rs1  in  5  rs1 of instruction in EX
ex_rs2  in  5  rs2 of instruction in EX
ex_rd  in  5  rd of instruction in EX
ex_is_load  in  1  EX instruction is a load (WDSel==01)
ex_redirect  in  1  EX resolved taken branch / jal / jalr
mem_rd  in  5  rd in MEM
mem_regwrite  in  1  MEM instruction writes rd
mem_op  in  1  MEM instruction is load or store
wb_rd  in  5  rd in WB
wb_regwrite  in  1  WB instruction writes rd
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  data memory request
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  clear IF/ID register (insert nop)
flush_ex  out  1  clear ID/EX register (insert bubble)
freeze  out  1  hold all pipeline registers (PC through MEM/WB)
fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM, 01 WB
fwd_b  out  2  EX operand B select, same encoding
mem_err  out  1  one-cycle pulse: memory timeout abort
stall_cycles  out  CNT_W  saturating count of stall/freeze cycles

Behaviour:
- States: S_RUN, S_MEMWAIT; 2-bit encoding, 4-bit timeout counter tcnt (wide enough for MEM_TIMEOUT).
- Reset (async): state S_RUN, tcnt 0, mem_err 0, stall_cycles 0. While rst high, all combinational outputs are forced 0.
- dmem_req = mem_op in both states.
- S_RUN:
  - mem_op & dmem_ack: zero-wait access; no freeze.
  - mem_op & ~dmem_ack: freeze=1 this cycle; next state S_MEMWAIT, tcnt←1.
- S_MEMWAIT:
  - freeze = ~dmem_ack.
  - On dmem_ack: next state S_RUN, tcnt←0; pipeline advances in the ack cycle.
  - On ~dmem_ack & tcnt==MEM_TIMEOUT-1: freeze=0, mem_err←1 for the next cycle only, next state S_RUN; the access is treated as complete.
  - Otherwise tcnt increments.
- Load-use hazard: hz = ex_is_load & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority, highest first:
  1. freeze: stall_if, stall_id, flush_* all 0; freeze dominates and nothing moves.
  2. ex_redirect: flush_id=1, flush_ex=1, stalls 0.
  3. hz: stall_if=1, stall_id=1, flush_ex=1. Exactly one bubble, because next cycle the load is in MEM.
- A redirect or hazard that is masked by freeze persists, because EX holds, and is acted on in the first unfrozen cycle.
- Forwarding (combinational, x0 never forwarded):
  - fwd_a=10 if mem_regwrite & mem_rd≠0 & mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_regwrite & wb_rd≠0 & wb_rd==ex_rs1.
  - Else fwd_a=00. fwd_b is the same using ex_rs2.
  - MEM has priority over WB.
- stall_cycles increments on every cycle with freeze | (hz & ~ex_redirect); it holds at 2^CNT_W-1.
- Reset asserted mid-S_MEMWAIT returns to S_RUN immediately; no mem_err is generated.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 (use_rs1=1) -> one cycle with stall_if=stall_id=flush_ex=1, then 0; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Forward priority: ex_rs1=7, mem_rd=7/mem_regwrite=1, wb_rd=7/wb_regwrite=1 -> fwd_a=10. Clear mem_regwrite -> fwd_a=01. Set rd=0 -> fwd_a=00.
- Memory wait: mem_op=1, dmem_ack arrives 3 cycles later -> freeze high 3 cycles, low in the ack cycle; state back to S_RUN; stall_cycles +3.
- Timeout: mem_op=1, never ack, MEM_TIMEOUT=16 -> freeze high 15 cycles, drops in cycle 16, mem_err pulses exactly once the following cycle.
- Redirect vs hazard: ex_redirect=1 with a simultaneous load-use hz -> flush_id=flush_ex=1, stall_if=0, stall_cycles unchanged. Same with freeze active -> all flush/stall 0 until freeze clears, then the flush occurs.
- Async reset mid-S_MEMWAIT -> outputs 0 immediately, counter 0, no mem_err after release.
